spi_slave: RTL and testbench

- SPI Mode 0 responder (CPOL=0, CPHA=0), MSB first, fixed frame length.
- Forms the other end of the team's SPI master link.
- Oversamples spi_clk, cs and mosi in the local sys_clk domain.
- Exchanges parallel words with the local core over a one-entry TX holding buffer (valid/ready) and a one-cycle RX valid pulse.

---
 rtl/spi_pkg.sv | 7 +
 rtl/spi_slave_if.sv | 25 ++
 rtl/spi_sync_edge.sv | 20 ++
 rtl/spi_slave.sv | 104 ++++++++++
 tb/tb_spi_slave.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and default parameters for the SPI responder
package spi_pkg;
    localparam int REG_WIDTH_DEF  = 8;
    localparam int TRANS_SIZE_DEF = 8;
    localparam logic [REG_WIDTH_DEF-1:0] IDLE_WORD_DEF = '0;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: serial pins plus TX/RX word handshake of the SPI responder
//   serial: spi_clk, cs (active low), mosi in; miso, miso_oe out
//   core:   tx_data/tx_valid in, tx_ready out; rx_data/rx_valid, underrun, abort out
interface spi_slave_if #(parameter int REG_WIDTH = 8);
    logic                 spi_clk;
    logic                 cs;
    logic                 mosi;
    logic                 miso;
    logic                 miso_oe;
    logic [REG_WIDTH-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [REG_WIDTH-1:0] rx_data;
    logic                 rx_valid;
    logic                 underrun;
    logic                 abort;
    modport slave (
        input  spi_clk, cs, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, abort
    );
    modport master (
        output spi_clk, cs, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, underrun, abort
    );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with a third flop for edge strobes
//   sys_clk, rst: local clock, sync active-high reset (flops load RST_VAL)
//   din: asynchronous input; level: synchronized value; rise/fall: one-cycle strobes
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;
    always_ff @(posedge sys_clk)
        sr <= rst ? {3{RST_VAL}} : {sr[1:0], din};
    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0 responder, MSB first, oversampled in the sys_clk domain
//   sys_clk, rst: local clock, sync active-high reset
//   bus (spi_slave_if.slave): serial pins, one-entry TX buffer, RX pulse, status
module spi_slave
    import spi_pkg::*;
#(
    parameter int REG_WIDTH     = REG_WIDTH_DEF,
    parameter int TRANS_SIZE    = TRANS_SIZE_DEF,
    parameter int COUNTER_WIDTH = $clog2(REG_WIDTH),
    parameter logic [REG_WIDTH-1:0] IDLE_WORD = REG_WIDTH'(IDLE_WORD_DEF)
) (
    input logic       sys_clk,
    input logic       rst,
    spi_slave_if.slave bus
);
    localparam logic [COUNTER_WIDTH:0] LAST    = (COUNTER_WIDTH+1)'(TRANS_SIZE);
    localparam logic [COUNTER_WIDTH:0] LAST_M1 = (COUNTER_WIDTH+1)'(TRANS_SIZE - 1);
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;
    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (.sys_clk, .rst, .din(bus.spi_clk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs   (.sys_clk, .rst, .din(bus.cs),      .level(cs_lvl),   .rise(cs_rise),   .fall(cs_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.sys_clk, .rst, .din(bus.mosi),    .level(mosi_s),   .rise(mosi_rise), .fall(mosi_fall));
    assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};
    state_t                 state;
    logic [REG_WIDTH-1:0]   tx_shift, rx_shift, buf_data, rx_data;
    logic [COUNTER_WIDTH:0] count;
    logic                   buf_full, reload, miso_oe, rx_valid, underrun, abort;
    logic [REG_WIDTH-1:0]   next_word;
    assign next_word    = buf_full ? buf_data : IDLE_WORD;
    assign bus.miso     = miso_oe & tx_shift[REG_WIDTH-1];
    assign bus.miso_oe  = miso_oe;
    assign bus.tx_ready = ~buf_full;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.underrun = underrun;
    assign bus.abort    = abort;
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            buf_data <= '0;
            rx_data  <= '0;
            count    <= '0;
            buf_full <= 1'b0;
            reload   <= 1'b0;
            miso_oe  <= 1'b0;
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            abort    <= 1'b0;
            // the buffer is only written while empty, so it never collides with a consume
            if (bus.tx_valid && !buf_full) begin
                buf_data <= bus.tx_data;
                buf_full <= 1'b1;
            end
            case (state)
                IDLE: if (cs_fall) state <= LOAD;
                LOAD: begin
                    tx_shift <= next_word;
                    underrun <= underrun | ~buf_full;
                    if (buf_full) buf_full <= 1'b0;
                    count    <= '0;
                    reload   <= 1'b0;
                    miso_oe  <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (count == LAST) begin
                        rx_data  <= rx_shift << (REG_WIDTH - TRANS_SIZE);
                        rx_valid <= 1'b1;
                        count    <= '0;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[REG_WIDTH-2:0], mosi_s};
                        count    <= count + 1'b1;
                        if (count == LAST_M1) reload <= 1'b1;
                    end
                    // the fall after a frame's last bit presents the next word instead of shifting
                    if (sclk_fall) begin
                        if (reload) begin
                            tx_shift <= next_word;
                            underrun <= underrun | ~buf_full;
                            if (buf_full) buf_full <= 1'b0;
                            reload   <= 1'b0;
                        end else begin
                            tx_shift <= tx_shift << 1;
                        end
                    end
                    if (cs_rise) begin
                        abort   <= count != '0 && count != LAST;
                        count   <= '0;
                        miso_oe <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed and random SPI mode 0 frames against a word-level model
module tb_spi_slave;
    import spi_pkg::*;
    localparam int W = 8;
    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    always #5 sys_clk = ~sys_clk;
    spi_slave_if #(.REG_WIDTH(W)) bus ();
    spi_slave #(.REG_WIDTH(W), .TRANS_SIZE(8)) dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    int rxv_cycles = 0;
    int abort_cycles = 0;
    logic [W-1:0] got_rx[$];
    logic [W-1:0] exp_rx[$];
    bit m_full, m_underrun;
    logic [W-1:0] m_buf, m_rx, exp_tx, mo_acc;
    int m_rxn, m_aborts;
    always @(posedge sys_clk) begin
        if (bus.rx_valid) begin
            rxv_cycles++;
            got_rx.push_back(bus.rx_data);
        end
        if (bus.abort) abort_cycles++;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [W-1:0] pop();
        if (m_full) begin
            m_full = 1'b0;
            return m_buf;
        end
        m_underrun = 1'b1;
        return IDLE_WORD_DEF;
    endfunction
    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask
    task automatic write_tx(input logic [W-1:0] w);
        chk("tx_ready before write", bus.tx_ready, !m_full);
        bus.tx_valid = 1'b1;
        bus.tx_data  = w;
        tick(1);
        bus.tx_valid = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = w;
        end
    endtask
    task automatic start_frame();
        bus.cs = 1'b0;
        tick(3);
        chk("miso_oe before load", bus.miso_oe, 0);
        chk("tx_ready before load", bus.tx_ready, !m_full);
        tick(1);
        exp_tx = pop();
        chk("miso_oe after load", bus.miso_oe, 1);
        chk("tx_ready after load", bus.tx_ready, 1);
    endtask
    task automatic run_bits(input int n, input logic [15:0] mo, input bit mid,
                            input logic [W-1:0] w0, input logic [W-1:0] w1);
        for (int i = 0; i < n; i++) begin
            bus.mosi = mo[15-i];
            if (mid && i % 8 == 2) begin
                write_tx(i < 8 ? w0 : w1);
                tick(3);
            end else begin
                tick(4);
            end
            chk($sformatf("miso bit %0d", i), bus.miso, exp_tx[7 - i % 8]);
            bus.spi_clk = 1'b1;
            mo_acc = {mo_acc[W-2:0], mo[15-i]};
            tick(4);
            bus.spi_clk = 1'b0;
            if (i % 8 == 7) begin
                m_rx = mo_acc;
                m_rxn++;
                exp_rx.push_back(mo_acc);
                exp_tx = pop();
            end
        end
    endtask
    task automatic end_frame();
        tick(4);
        bus.cs = 1'b1;
        tick(8);
        while (got_rx.size() > 0 && exp_rx.size() > 0)
            chk("rx word", got_rx.pop_front(), exp_rx.pop_front());
        chk("rx_valid cycles", rxv_cycles, m_rxn);
        chk("rx_data", bus.rx_data, m_rx);
        chk("abort cycles", abort_cycles, m_aborts);
        chk("underrun", bus.underrun, m_underrun);
        chk("miso_oe deselected", bus.miso_oe, 0);
    endtask
    task automatic chk_reset_outputs();
        chk("rst miso", bus.miso, 0);
        chk("rst miso_oe", bus.miso_oe, 0);
        chk("rst tx_ready", bus.tx_ready, 1);
        chk("rst rx_valid", bus.rx_valid, 0);
        chk("rst rx_data", bus.rx_data, 0);
        chk("rst underrun", bus.underrun, 0);
        chk("rst abort", bus.abort, 0);
    endtask
    initial begin
        logic [W-1:0] a, b;
        bus.spi_clk = 1'b0;
        bus.cs = 1'b1;
        bus.mosi = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data = '0;
        m_full = 1'b0;
        m_underrun = 1'b0;
        m_buf = '0;
        m_rx = '0;
        mo_acc = '0;
        exp_tx = '0;
        m_rxn = 0;
        m_aborts = 0;
        tick(3);
        chk_reset_outputs();
        rst = 1'b0;
        tick(2);
        // basic frame; the F0 refill feeds the reload after the last bit
        write_tx(8'hA5);
        tick(2);
        start_frame();
        run_bits(8, {8'h3C, 8'h00}, 1'b1, 8'hF0, 8'h00);
        end_frame();
        chk("basic rx_data", bus.rx_data, 8'h3C);
        chk("basic underrun", bus.underrun, 0);
        // back-to-back frames with cs held low
        write_tx(8'h81);
        start_frame();
        run_bits(16, 16'h5AC3, 1'b1, 8'h7E, W'($urandom));
        end_frame();
        chk("b2b abort", abort_cycles, 0);
        // underrun: frame started with an empty buffer
        start_frame();
        run_bits(8, {W'($urandom), 8'h00}, 1'b0, 8'h00, 8'h00);
        end_frame();
        write_tx(W'($urandom));
        start_frame();
        run_bits(8, {W'($urandom), 8'h00}, 1'b1, W'($urandom), 8'h00);
        end_frame();
        chk("underrun sticky", bus.underrun, 1);
        // abort after five bits
        a = bus.rx_data;
        write_tx(W'($urandom));
        start_frame();
        run_bits(5, {W'($urandom), 8'h00}, 1'b0, 8'h00, 8'h00);
        m_aborts++;
        end_frame();
        chk("abort keeps rx_data", bus.rx_data, a);
        write_tx(W'($urandom));
        start_frame();
        run_bits(8, {W'($urandom), 8'h00}, 1'b0, 8'h00, 8'h00);
        end_frame();
        // reset at bit 3
        write_tx(W'($urandom));
        start_frame();
        run_bits(3, {W'($urandom), 8'h00}, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        tick(1);
        chk_reset_outputs();
        bus.cs = 1'b1;
        tick(4);
        rst = 1'b0;
        m_full = 1'b0;
        m_underrun = 1'b0;
        m_rx = '0;
        tick(2);
        b = W'($urandom);
        write_tx(W'($urandom));
        start_frame();
        run_bits(8, {b, 8'h00}, 1'b1, W'($urandom), 8'h00);
        end_frame();
        chk("post-reset rx_data", bus.rx_data, b);
        // deselected: clock toggling with cs high
        for (int i = 0; i < 8; i++) begin
            bus.mosi = 1'($urandom);
            bus.spi_clk = 1'b1;
            tick(2);
            chk("desel miso_oe", bus.miso_oe, 0);
            chk("desel miso", bus.miso, 0);
            bus.spi_clk = 1'b0;
            tick(2);
        end
        tick(4);
        chk("desel rx_valid", rxv_cycles, m_rxn);
        // random frames
        for (int f = 0; f < 4; f++) begin
            if ($urandom_range(0, 3) != 0) write_tx(W'($urandom));
            tick(1);
            start_frame();
            run_bits(8 * $urandom_range(1, 2), 16'($urandom), 1'($urandom), W'($urandom), W'($urandom));
            end_frame();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
